// File: rtl/mm_operand_feeder.sv
// Operand feeder for the 2x2 systolic matrix-multiply array.
// Captures one (A, B) operand pair, pulses a clear to the array, drives the
// skewed west/north wavefronts over three cycles, then waits (bounded) for
// the array to report completion.
module mm_operand_feeder #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               load_valid_i,
   output logic               load_ready_o,
   input  logic [4*WIDTH-1:0] mat_a_i,
   input  logic [4*WIDTH-1:0] mat_b_i,
   output logic               array_clear_o,
   output logic               array_start_o,
   output logic               array_shift_o,
   output logic [WIDTH-1:0]   west0_o,
   output logic [WIDTH-1:0]   west1_o,
   output logic [WIDTH-1:0]   north0_o,
   output logic [WIDTH-1:0]   north1_o,
   input  logic               array_done_i,
   output logic               busy_o,
   output logic               done_o,
   output logic               timeout_err_o
);

   // Counter only needs to reach TIMEOUT-1; keep at least one bit.
   localparam int unsigned   CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StFeed,
      StDrain,
      StFinish
   } state_e;

   state_e             state_q, state_d;
   logic [1:0]         phase_q, phase_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [4*WIDTH-1:0] a_q, a_d;
   logic [4*WIDTH-1:0] b_q, b_d;
   logic               err_q, err_d;

   logic [WIDTH-1:0] a00, a01, a10, a11;
   logic [WIDTH-1:0] b00, b01, b10, b11;

   assign a00 = a_q[0*WIDTH +: WIDTH];
   assign a01 = a_q[1*WIDTH +: WIDTH];
   assign a10 = a_q[2*WIDTH +: WIDTH];
   assign a11 = a_q[3*WIDTH +: WIDTH];
   assign b00 = b_q[0*WIDTH +: WIDTH];
   assign b01 = b_q[1*WIDTH +: WIDTH];
   assign b10 = b_q[2*WIDTH +: WIDTH];
   assign b11 = b_q[3*WIDTH +: WIDTH];

   // State, phase/timeout counters, captured operands and sticky error flag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         phase_q <= '0;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic: operands are only captured on acceptance in idle.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            if (load_valid_i) begin
               a_d     = mat_a_i;
               b_d     = mat_b_i;
               err_d   = 1'b0;
               state_d = StClear;
            end
         end
         StClear: begin
            phase_d = 2'd0;
            state_d = StFeed;
         end
         StFeed: begin
            if (phase_q == 2'd2) begin
               cnt_d   = '0;
               state_d = StDrain;
            end else begin
               phase_d = phase_q + 2'd1;
            end
         end
         StDrain: begin
            // Completion takes priority over a timeout on the same cycle.
            if (array_done_i) begin
               state_d = StFinish;
            end else if (cnt_q == CntLast) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StFinish: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs decoded from registered state; operands are skewed by phase.
   always_comb begin
      load_ready_o  = 1'b0;
      array_clear_o = 1'b0;
      array_start_o = 1'b0;
      array_shift_o = 1'b0;
      busy_o        = 1'b1;
      done_o        = 1'b0;
      timeout_err_o = err_q;
      west0_o       = '0;
      west1_o       = '0;
      north0_o      = '0;
      north1_o      = '0;
      unique case (state_q)
         StIdle: begin
            load_ready_o = 1'b1;
            busy_o       = 1'b0;
         end
         StClear: begin
            array_clear_o = 1'b1;
         end
         StFeed: begin
            array_start_o = 1'b1;
            array_shift_o = 1'b1;
            case (phase_q)
               2'd0: begin
                  west0_o  = a00;
                  north0_o = b00;
               end
               2'd1: begin
                  west0_o  = a01;
                  west1_o  = a10;
                  north0_o = b10;
                  north1_o = b01;
               end
               2'd2: begin
                  west1_o  = a11;
                  north1_o = b11;
               end
               default: begin
                  west0_o = '0;
               end
            endcase
         end
         StDrain: begin
            array_start_o = 1'b1;
         end
         StFinish: begin
            done_o = 1'b1;
         end
         default: begin
            busy_o = 1'b1;
         end
      endcase
   end

endmodule
